// File: rtl/mul_iter_seq.sv
// Iterative shift-and-add mantissa multiplier: one WIDTH-bit CLA reused over WIDTH cycles.
// Optional MUL_STICKY_EN adds o_sticky = OR of the low product half, for rounding.
module mul_iter_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_mant_a,
  input  logic [WIDTH-1:0]   i_mant_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product,
`ifdef MUL_STICKY_EN
  output logic               o_sticky,
`endif
  output logic               o_busy
);

  localparam int unsigned NS  = WIDTH / 4;
  localparam logic        CIN = 1'b0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, acc_hi_q, acc_lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, running, last_iter;

  logic [WIDTH-1:0]   addend, sum, bit_p, bit_g, bit_c;
  logic [NS-1:0]      grp_p, grp_g;
  logic [NS:0]        grp_c;
  logic               run_p;
  logic               carry;
  logic [WIDTH-1:0]   acc_lo_next;

  // Adder: 4-bit slices export P/G; the group unit expands every slice carry-in directly.
  always_comb begin
    addend = acc_lo_q[0] ? mcand_q : '0;
    bit_p  = acc_hi_q ^ addend;
    bit_g  = acc_hi_q & addend;
    for (int unsigned s = 0; s < NS; s++) begin
      grp_p[s] = &bit_p[4*s +: 4];
      grp_g[s] = bit_g[4*s+3]
               | (bit_p[4*s+3] & bit_g[4*s+2])
               | (bit_p[4*s+3] & bit_p[4*s+2] & bit_g[4*s+1])
               | (bit_p[4*s+3] & bit_p[4*s+2] & bit_p[4*s+1] & bit_g[4*s]);
    end
    grp_c    = '0;
    grp_c[0] = CIN;
    run_p    = 1'b1;
    for (int unsigned j = 1; j <= NS; j++) begin
      run_p = 1'b1;
      for (int unsigned k = j; k > 0; k--) begin
        grp_c[j] = grp_c[j] | (grp_g[k-1] & run_p);
        run_p    = run_p & grp_p[k-1];
      end
      grp_c[j] = grp_c[j] | (CIN & run_p);
    end
    bit_c = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      bit_c[4*s] = grp_c[s];
      for (int unsigned i = 1; i < 4; i++) begin
        bit_c[4*s+i] = bit_g[4*s+i-1] | (bit_p[4*s+i-1] & bit_c[4*s+i-1]);
      end
    end
    sum   = bit_p ^ bit_c;
    carry = grp_c[NS];
  end

  assign accept      = (state_q == IDLE) && i_valid;
  assign running     = (state_q == RUN);
  assign last_iter   = running && (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_lo_next = {sum[0], acc_lo_q[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Right shift of {carry, sum, acc_lo}: the adder carry-out becomes the new MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      mcand_q  <= i_mant_a;
      acc_hi_q <= '0;
      acc_lo_q <= i_mant_b;
      cnt_q    <= '0;
    end else if (running) begin
      acc_hi_q <= {carry, sum[WIDTH-1:1]};
      acc_lo_q <= acc_lo_next;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  assign o_product = {acc_hi_q, acc_lo_q};

`ifdef MUL_STICKY_EN
  logic sticky_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (last_iter) begin
      sticky_q <= |acc_lo_next;
    end
  end

  assign o_sticky = sticky_q;
`endif

endmodule
